mcu_row_reader: RTL and testbench

- Reads one completed MCU row (40 MCUs × 64 pixels) out of the 5-EBR double buffer written by the camera ingester.
- Emits pixels MCU by MCU, each MCU in raster order (py-major, px-minor), over a valid/ready stream to the downstream DCT/JPEG pipeline.
- Tags every pixel with the MCU's obfuscation bit from the row obfuscation map.
- Reads the backbuffer while the ingester fills the frontbuffer.

---
 rtl/jfpjc_pkg.sv | 36 +++
 rtl/mcu_skid_buffer.sv | 48 ++++
 rtl/mcu_row_reader.sv | 183 ++++++++++++++++++
 tb/tb_mcu_row_reader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/jfpjc_pkg.sv
// Shared constants, reader state encoding and the output beat format for the
// camera-to-JPEG block path.
package jfpjc_pkg;

    localparam int unsigned WIDTH_PIX  = 320;
    localparam int unsigned HEIGHT_PIX = 240;
    localparam int unsigned NUM_EBR    = 5;
    localparam int unsigned EBR_SIZE   = 512;

    localparam int unsigned WIDTH_MCU  = WIDTH_PIX / 8;
    localparam int unsigned HEIGHT_MCU = HEIGHT_PIX / 8;
    localparam int unsigned MCU_PIXELS = 64;
    localparam int unsigned EBR_ADDR_W = $clog2(EBR_SIZE);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain
    } reader_state_e;

    typedef struct packed {
        logic [7:0] pixval;
        logic       first;
        logic       last;
        logic [5:0] index;
        logic       obfuscate;
    } mcu_beat_t;

    localparam int unsigned BEAT_W = $bits(mcu_beat_t);

    // MCU k sits in EBR block k mod NUM_EBR, address group k div NUM_EBR.
    function automatic logic [5:0] mcu_index_of(input logic [2:0] grp, input logic [2:0] blk);
        return 6'(grp) * 6'(NUM_EBR) + 6'(blk);
    endfunction

endpackage

// File: rtl/mcu_skid_buffer.sv
// Two-entry valid/ready FIFO; occupancy is exported so the producer can run
// credit-based flow control around its read latency.
module mcu_skid_buffer #(
    parameter int unsigned Width = 8
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [Width-1:0] o_data,
    output logic [1:0]       o_occupancy
);

    logic [Width-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_valid     = (r_count != 2'd0);
    assign o_data      = r_mem[r_rd_ptr];
    assign o_occupancy = r_count;
    assign w_pop       = o_valid && i_ready;
    assign w_push      = i_push && (r_count != 2'd2);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/mcu_row_reader.sv
// Streams one completed MCU row out of the EBR backbuffer, MCU by MCU.
// Optional MCU_READER_OBFUSCATE_ZERO_EN blanks pixels of obfuscated MCUs.
module mcu_row_reader
    import jfpjc_pkg::*;
(
    input  logic        clock,
    input  logic        nreset,
    input  logic        frontbuffer_select,
    input  logic [39:0] obfuscation_map_in,
    output logic        ebr_buffer_select,
    output logic [2:0]  ebr_block_select,
    output logic [8:0]  ebr_read_addr,
    output logic        ebr_rden,
    input  logic [7:0]  ebr_read_data,
    output logic [7:0]  mcu_pixval,
    output logic        mcu_valid,
    input  logic        mcu_ready,
    output logic        mcu_first,
    output logic        mcu_last,
    output logic [5:0]  mcu_index,
    output logic        mcu_obfuscate,
    output logic        row_done,
    output logic        overrun
);

    localparam logic [2:0] BLK_MAX = 3'(NUM_EBR - 1);

    reader_state_e r_state, w_state_next;
    logic          r_fb_prev;
    logic          r_buf_sel;
    logic          r_overrun;
    logic [39:0]   r_map;
    logic [2:0]    r_px, r_py, r_blk, r_grp;
    logic          r_rd_vld, r_rd_first, r_rd_last, r_rd_obf;
    logic [5:0]    r_rd_index;

    logic          w_toggle, w_issue, w_start, w_row_done, w_last_addr;
    logic          w_credit, w_pop, w_skid_valid;
    logic [1:0]    w_occ;
    logic [2:0]    w_occ_eff;
    logic [5:0]    w_issue_index;
    mcu_beat_t     w_push_beat, w_head;

    assign w_toggle      = (frontbuffer_select != r_fb_prev);
    assign w_pop         = w_skid_valid && mcu_ready;
    assign w_issue_index = mcu_index_of(r_grp, r_blk);
    assign w_last_addr   = (r_grp == 3'd7) && (r_blk == BLK_MAX) && (r_py == 3'd7)
                           && (r_px == 3'd7);
    // Entries committed once this cycle settles, counting the read already returning.
    assign w_occ_eff     = {1'b0, w_occ} + {2'b0, r_rd_vld} - {2'b0, w_pop};
    assign w_credit      = (w_occ_eff < 3'd2);

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_start      = 1'b0;
        w_row_done   = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_toggle) begin
                    w_start      = 1'b1;
                    w_state_next = StStream;
                end
            end
            StStream: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (w_last_addr) w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_pop && w_head.last && (w_head.index == 6'(WIDTH_MCU - 1))) begin
                    w_row_done   = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state   <= StIdle;
            r_fb_prev <= 1'b0;
            r_buf_sel <= 1'b0;
            r_overrun <= 1'b0;
            r_map     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_fb_prev <= frontbuffer_select;
            if (w_start) begin
                r_buf_sel <= r_fb_prev;
                r_map     <= obfuscation_map_in;
            end
            if (w_toggle && (r_state != StIdle)) r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_px  <= 3'd0;
            r_py  <= 3'd0;
            r_blk <= 3'd0;
            r_grp <= 3'd0;
        end else if (w_start) begin
            r_px  <= 3'd0;
            r_py  <= 3'd0;
            r_blk <= 3'd0;
            r_grp <= 3'd0;
        end else if (w_issue) begin
            r_px <= r_px + 3'd1;
            if (r_px == 3'd7) begin
                r_py <= r_py + 3'd1;
                if (r_py == 3'd7) begin
                    if (r_blk == BLK_MAX) begin
                        r_blk <= 3'd0;
                        r_grp <= r_grp + 3'd1;
                    end else begin
                        r_blk <= r_blk + 3'd1;
                    end
                end
            end
        end
    end

    // Sideband travels alongside the one-cycle EBR read latency.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_rd_vld   <= 1'b0;
            r_rd_first <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_index <= 6'd0;
            r_rd_obf   <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_first <= (r_px == 3'd0) && (r_py == 3'd0);
                r_rd_last  <= (r_px == 3'd7) && (r_py == 3'd7);
                r_rd_index <= w_issue_index;
                r_rd_obf   <= r_map[w_issue_index];
            end
        end
    end

    always_comb begin
        w_push_beat.first     = r_rd_first;
        w_push_beat.last      = r_rd_last;
        w_push_beat.index     = r_rd_index;
        w_push_beat.obfuscate = r_rd_obf;
`ifdef MCU_READER_OBFUSCATE_ZERO_EN
        w_push_beat.pixval    = r_rd_obf ? 8'h00 : ebr_read_data;
`else
        w_push_beat.pixval    = ebr_read_data;
`endif
    end

    mcu_skid_buffer #(
        .Width (BEAT_W)
    ) u_skid (
        .clock       (clock),
        .nreset      (nreset),
        .i_push      (r_rd_vld),
        .i_data      (w_push_beat),
        .o_valid     (w_skid_valid),
        .i_ready     (mcu_ready),
        .o_data      (w_head),
        .o_occupancy (w_occ)
    );

    assign ebr_buffer_select = r_buf_sel;
    assign ebr_block_select  = r_blk;
    assign ebr_read_addr     = {r_grp, r_py, r_px};
    assign ebr_rden          = w_issue;
    assign mcu_pixval        = w_head.pixval;
    assign mcu_valid         = w_skid_valid;
    assign mcu_first         = w_head.first;
    assign mcu_last          = w_head.last;
    assign mcu_index         = w_head.index;
    assign mcu_obfuscate     = w_head.obfuscate;
    assign row_done          = w_row_done;
    assign overrun           = r_overrun;

endmodule

// File: tb/tb_mcu_row_reader.sv
// Randomized bench for mcu_row_reader against a row-level reference model.
module tb_mcu_row_reader;

    logic        clock = 1'b0;
    logic        nreset;
    logic        frontbuffer_select;
    logic [39:0] obfuscation_map_in;
    logic        ebr_buffer_select;
    logic [2:0]  ebr_block_select;
    logic [8:0]  ebr_read_addr;
    logic        ebr_rden;
    logic [7:0]  ebr_read_data;
    logic [7:0]  mcu_pixval;
    logic        mcu_valid;
    logic        mcu_ready;
    logic        mcu_first;
    logic        mcu_last;
    logic [5:0]  mcu_index;
    logic        mcu_obfuscate;
    logic        row_done;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mcu_row_reader dut (
        .clock              (clock),
        .nreset             (nreset),
        .frontbuffer_select (frontbuffer_select),
        .obfuscation_map_in (obfuscation_map_in),
        .ebr_buffer_select  (ebr_buffer_select),
        .ebr_block_select   (ebr_block_select),
        .ebr_read_addr      (ebr_read_addr),
        .ebr_rden           (ebr_rden),
        .ebr_read_data      (ebr_read_data),
        .mcu_pixval         (mcu_pixval),
        .mcu_valid          (mcu_valid),
        .mcu_ready          (mcu_ready),
        .mcu_first          (mcu_first),
        .mcu_last           (mcu_last),
        .mcu_index          (mcu_index),
        .mcu_obfuscate      (mcu_obfuscate),
        .row_done           (row_done),
        .overrun            (overrun)
    );

    // EBR model: synchronous read, data one cycle after the strobe.
    always @(posedge clock) begin
        if (ebr_rden)
            ebr_read_data <= 8'((int'(ebr_block_select) * 37 + int'(ebr_read_addr)) & 255);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] all_outs();
        return {ebr_buffer_select, ebr_block_select, ebr_read_addr, ebr_rden, mcu_pixval,
                mcu_valid, mcu_first, mcu_last, mcu_index, mcu_obfuscate, row_done, overrun};
    endfunction

    // Beat n of a row: MCU k = n/64 lives in block k%5 at address (k/5)*64 + pixel.
    function automatic logic [17:0] exp_beat(input int n, input logic [39:0] map);
        int k, p, blk, addr;
        logic [7:0] pix;
        logic obf;
        k    = n / 64;
        p    = n % 64;
        blk  = k % 5;
        addr = (k / 5) * 64 + p;
        pix  = 8'((blk * 37 + addr) & 255);
        obf  = map[k];
`ifdef MCU_READER_OBFUSCATE_ZERO_EN
        if (obf) pix = 8'h00;
`endif
        return {pix, (p == 0), (p == 63), 6'(k), obf, (n == 2559)};
    endfunction

    task automatic run_row(input logic [39:0] map, input int duty, input int ovr_at,
                           input int abort_at);
        int n, cyc, ovr_cyc, extra;
        bit stall, done, do_ovr, do_abort;
        logic exp_buf;
        logic [17:0] prev, obs;
        n = 0; cyc = 0; ovr_cyc = -1; extra = 0;
        stall = 0; done = 0; do_ovr = 0; do_abort = 0;
        prev = '0;
        exp_buf = frontbuffer_select;
        @(posedge clock); #1;
        obfuscation_map_in = map;
        frontbuffer_select = ~frontbuffer_select;
        mcu_ready = ($urandom_range(99) < duty);
        while (!done && cyc < 20000) begin
            @(negedge clock);
            obs = {mcu_pixval, mcu_first, mcu_last, mcu_index, mcu_obfuscate, row_done};
            if (stall) check_eq("stall_hold", {45'd0, mcu_valid, obs}, {45'd0, 1'b1, prev});
            if (ovr_cyc >= 0 && cyc == ovr_cyc) check_eq("overrun_pre", 64'(overrun), 64'd0);
            if (ovr_cyc >= 0 && cyc == ovr_cyc + 1) check_eq("overrun_set", 64'(overrun), 64'd1);
            if (mcu_valid && mcu_ready) begin
                if (n == 0) begin
                    check_eq("buf_sel", 64'(ebr_buffer_select), 64'(exp_buf));
                    if (duty >= 100) check_eq("latency", 64'(cyc), 64'd3);
                end
                check_eq("beat", 64'(obs), 64'(exp_beat(n, map)));
                n++;
                if (n == 2560) done = 1;
                if (n == ovr_at) do_ovr = 1;
                if (n == abort_at) do_abort = 1;
            end else if (row_done) begin
                check_eq("row_done_idle", 64'(row_done), 64'd0);
            end
            stall = mcu_valid && !mcu_ready;
            prev  = obs;
            if (!done) begin
                @(posedge clock); #1;
                cyc++;
                mcu_ready = ($urandom_range(99) < duty);
                if (do_ovr) begin
                    do_ovr = 0;
                    frontbuffer_select = ~frontbuffer_select;
                    ovr_cyc = cyc;
                end
                if (do_abort) begin
                    nreset = 1'b0;
                    #1;
                    check_eq("abort_outs", 64'(all_outs()), 64'd0);
                    repeat (3) @(posedge clock);
                    #1;
                    nreset = 1'b1;
                    return;
                end
            end
        end
        check_eq("beat_count", 64'(n), 64'd2560);
        @(posedge clock); #1;
        mcu_ready = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (mcu_valid) extra++;
        end
        check_eq("no_extra", 64'(extra), 64'd0);
    endtask

    initial begin
        int busy;
        logic [39:0] rmap;
        nreset             = 1'b0;
        frontbuffer_select = 1'bx;
        obfuscation_map_in = 'x;
        mcu_ready          = 1'bx;
        repeat (2) @(posedge clock);
        #1;
        check_eq("reset_outs", 64'(all_outs()), 64'd0);
        frontbuffer_select = 1'b0;
        obfuscation_map_in = '0;
        mcu_ready          = 1'b1;
        @(posedge clock); #1;
        nreset = 1'b1;
        busy = 0;
        repeat (100) begin
            @(negedge clock);
            if (ebr_rden || mcu_valid) busy++;
        end
        check_eq("idle_quiet", 64'(busy), 64'd0);

        run_row(40'd0, 100, -1, -1);
        check_eq("no_overrun", 64'(overrun), 64'd0);

        run_row(40'h00_0000_0021, 30, -1, -1);

        rmap = {8'($urandom), $urandom};
        run_row(rmap, 100, 1000, -1);
        repeat (10) @(posedge clock);
        #1;
        check_eq("overrun_sticky", 64'(overrun), 64'd1);

        nreset = 1'b0;
        #1;
        check_eq("reset_clears", 64'(all_outs()), 64'd0);
        @(posedge clock); #1;
        nreset = 1'b1;

        rmap = {8'($urandom), $urandom};
        run_row(rmap, 70, -1, -1);

        rmap = {8'($urandom), $urandom};
        run_row(rmap, 100, -1, 700);
        busy = 0;
        repeat (20) begin
            @(negedge clock);
            if (ebr_rden || mcu_valid) busy++;
        end
        check_eq("post_abort_idle", 64'(busy), 64'd0);

        run_row(40'h00_0000_0021, 100, -1, -1);
        check_eq("final_overrun", 64'(overrun), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
